// File: rtl/trellis_decision_packer.sv
// Trellis decision packer: qualifies, inverts and differentially decodes
// hard decisions, packs them MSB-first into bytes and buffers them in a FIFO.
module trellis_decision_packer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  symEn,
    input  logic                  decision,
    input  logic                  invert,
    input  logic                  diffEnable,
    input  logic                  resync,
    input  logic                  clearStatus,
    output logic [7:0]            byteOut,
    output logic                  byteValid,
    input  logic                  byteReady,
    output logic [DEPTH_LOG2:0]   fillLevel,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [6:0]            r_shift;
    logic [2:0]            r_bitCount;
    logic                  r_prevBit;
    logic [7:0]            r_pushData;
    logic                  r_pushPending;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;

    logic w_d;
    logic w_b;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Decision conditioning: inversion then optional differential decode
    always_comb begin
        w_d = decision ^ invert;
        w_b = diffEnable ? (w_d ^ r_prevBit) : w_d;
    end

    // FIFO handshake qualifiers; a pop frees the slot for a same-cycle write
    always_comb begin
        w_full = (r_count == FULL_LEVEL);
        w_pop  = byteValid & byteReady;
        w_push = r_pushPending & (~w_full | w_pop);
        w_drop = r_pushPending & w_full & ~w_pop;
    end

    // Bit assembly; resync restarts the byte, a coincident bit becomes its MSB
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift       <= '0;
            r_bitCount    <= '0;
            r_prevBit     <= 1'b0;
            r_pushData    <= '0;
            r_pushPending <= 1'b0;
        end else begin
            r_pushPending <= 1'b0;
            if (symEn) begin
                r_prevBit <= w_d;
                if (resync) begin
                    r_shift    <= {6'b0, w_b};
                    r_bitCount <= 3'd1;
                end else begin
                    r_shift    <= {r_shift[5:0], w_b};
                    r_bitCount <= r_bitCount + 3'd1;
                    if (r_bitCount == 3'd7) begin
                        r_pushData    <= {r_shift, w_b};
                        r_pushPending <= 1'b1;
                    end
                end
            end else if (resync) begin
                r_shift    <= '0;
                r_bitCount <= '0;
            end
        end
    end

    // FIFO storage, written only when a push is accepted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= r_pushData;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a drop in the clearing cycle keeps it set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clearStatus) begin
            r_overflow <= 1'b0;
        end
    end

    // Output view; head byte is masked to zero while empty
    always_comb begin
        byteValid = (r_count != '0);
        byteOut   = byteValid ? r_mem[r_rdPtr] : 8'h00;
        fillLevel = r_count;
        overflow  = r_overflow;
    end

endmodule

// File: tb/tb_trellis_decision_packer.sv
// Directed self-checking bench for trellis_decision_packer.
module tb_trellis_decision_packer;

    logic       clk = 1'b0;
    logic       reset;
    logic       symEn;
    logic       decision;
    logic       invert;
    logic       diffEnable;
    logic       resync;
    logic       clearStatus;
    logic [7:0] byteOut;
    logic       byteValid;
    logic       byteReady;
    logic [4:0] fillLevel;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    trellis_decision_packer #(.DEPTH_LOG2(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .symEn      (symEn),
        .decision   (decision),
        .invert     (invert),
        .diffEnable (diffEnable),
        .resync     (resync),
        .clearStatus(clearStatus),
        .byteOut    (byteOut),
        .byteValid  (byteValid),
        .byteReady  (byteReady),
        .fillLevel  (fillLevel),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        symEn    = 1'b1;
        decision = b;
        tick();
        symEn    = 1'b0;
        decision = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    task automatic pop_one();
        byteReady = 1'b1;
        tick();
        byteReady = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [7:0] pat;
    logic [7:0] dpat;

    initial begin
        reset       = 1'b0;
        symEn       = 1'b0;
        decision    = 1'b0;
        invert      = 1'b0;
        diffEnable  = 1'b0;
        resync      = 1'b0;
        clearStatus = 1'b0;
        byteReady   = 1'b0;
        do_reset();

        chk("rst_byteOut", 32'(byteOut), 32'h00);
        chk("rst_valid", 32'(byteValid), 32'd0);
        chk("rst_fill", 32'(fillLevel), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // 1,0,1,1,0,0,1,0 with the last strobe timed by hand
        pat = 8'b1011_0010;
        for (int i = 7; i >= 1; i--) begin
            send_bit(pat[i]);
        end
        symEn    = 1'b1;
        decision = pat[0];
        tick();
        symEn    = 1'b0;
        chk("lat_valid_n1", 32'(byteValid), 32'd0);
        tick();
        chk("lat_valid_n2", 32'(byteValid), 32'd1);
        chk("plain_byte", 32'(byteOut), 32'hB2);
        chk("plain_fill", 32'(fillLevel), 32'd1);
        pop_one();
        chk("plain_popped", 32'(byteValid), 32'd0);

        invert = 1'b1;
        send_byte(pat);
        invert = 1'b0;
        chk("invert_byte", 32'(byteOut), 32'h4D);
        pop_one();

        do_reset();
        diffEnable = 1'b1;
        dpat = 8'b1100_1011;
        send_byte(dpat);
        diffEnable = 1'b0;
        chk("diff_byte", 32'(byteOut), 32'hAE);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h5A);
        end
        chk("full_fill", 32'(fillLevel), 32'd16);
        chk("full_no_ovf", 32'(overflow), 32'd0);
        send_byte(8'h5A);
        chk("ovf_fill", 32'(fillLevel), 32'd16);
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), 32'(byteOut), 32'h5A);
            pop_one();
        end
        chk("drain_empty", 32'(byteValid), 32'd0);
        chk("drain_ovf_sticky", 32'(overflow), 32'd1);
        clearStatus = 1'b1;
        tick();
        clearStatus = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // resync with a coincident zero bit restarts the byte
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        symEn    = 1'b1;
        decision = 1'b0;
        resync   = 1'b1;
        tick();
        symEn    = 1'b0;
        resync   = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            send_bit(1'b0);
        end
        chk("resync_partial", 32'(fillLevel), 32'd0);
        send_bit(1'b0);
        chk("resync_fill", 32'(fillLevel), 32'd1);
        chk("resync_byte", 32'(byteOut), 32'h00);
        pop_one();

        // full FIFO, pop coincides with the push cycle
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h10 + i));
        end
        chk("order_full", 32'(fillLevel), 32'd16);
        pat = 8'hEE;
        for (int i = 7; i >= 1; i--) begin
            send_bit(pat[i]);
        end
        symEn    = 1'b1;
        decision = pat[0];
        tick();
        symEn     = 1'b0;
        byteReady = 1'b1;
        tick();
        byteReady = 1'b0;
        chk("swap_fill", 32'(fillLevel), 32'd16);
        chk("swap_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("order_%0d", i), 32'(byteOut), 32'(8'h10 + i));
            pop_one();
        end
        chk("order_last", 32'(byteOut), 32'hEE);
        chk("order_last_fill", 32'(fillLevel), 32'd1);

        // reset mid-byte with a byte still queued
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset = 1'b1;
        tick();
        chk("midrst_valid", 32'(byteValid), 32'd0);
        chk("midrst_fill", 32'(fillLevel), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        send_byte(8'hC3);
        chk("midrst_fresh_byte", 32'(byteOut), 32'hC3);
        chk("midrst_fresh_fill", 32'(fillLevel), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
